// File: rtl/line_writeback_buffer.sv
// Writes one captured 256-bit victim line to memory as a single 8-beat AXI4 INCR write burst.
// Optional feature: define WB_BRESP_CHECK_EN to raise a sticky err on a non-OKAY bresp.
//
// state | meaning
// IDLE  | buffer free, req_ready high, waiting for an eviction
// SEND  | AW and W channels active; the two complete independently
// RESP  | waiting for the B handshake
module line_writeback_buffer #(
  parameter int ID_WIDTH = 4,
  parameter int WB_ID    = 1,
  parameter int BEATS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [BEATS*32-1:0]   req_line,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BEATS*32-1:0] line_q, line_d;
  logic [26:0]         addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                err_q, err_d;

  logic aw_hs;
  logic w_hs;
  logic w_last_hs;
  logic b_hs;

  // bid is never checked and the low address bits are dropped by line alignment.
  logic unused_inputs;
  assign unused_inputs = ^{bid, req_addr[4:0]};

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign bready    = (state_q == RESP);

  assign awvalid = (state_q == SEND) && !aw_done_q;
  assign awid    = ID_WIDTH'(WB_ID);
  assign awaddr  = {addr_q, 5'b00000};
  assign awlen   = 8'(BEATS - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;

  assign wvalid = (state_q == SEND) && !w_done_q;
  assign wdata  = line_q[cnt_q*32 +: 32];
  assign wstrb  = 4'hF;
  assign wlast  = wvalid && (cnt_q == LAST_CNT);

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign w_last_hs = w_hs && wlast;
  assign b_hs      = bvalid && bready;

  assign done = b_hs;
  assign err  = err_q;

`ifndef WB_BRESP_CHECK_EN
  logic unused_bresp;
  assign unused_bresp = ^bresp;
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          line_d  = req_line;
          addr_d  = req_addr[31:5];
          state_d = SEND;
        end
      end

      SEND: begin
        if (aw_hs) aw_done_d = 1'b1;
        // The counter parks on the last beat; it is cleared when the burst retires.
        if (w_hs) begin
          if (cnt_q == LAST_CNT) w_done_d = 1'b1;
          else                   cnt_d    = cnt_q + CNT_W'(1);
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) state_d = RESP;
      end

      RESP: begin
        if (bvalid) begin
          state_d   = IDLE;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef WB_BRESP_CHECK_EN
          if (bresp != 2'b00) err_d = 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_line_writeback_buffer.sv
// Directed and randomized bench for line_writeback_buffer with a transaction-level AXI slave model.
// Build with WB_BRESP_CHECK_EN defined to exercise the sticky error flag.
module tb_line_writeback_buffer;

  localparam int ID_WIDTH = 4;
  localparam int WB_ID    = 1;
  localparam int BEATS    = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_addr;
  logic [255:0]        req_line;
  logic                busy;
  logic                done;
  logic                err;
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  line_writeback_buffer #(.ID_WIDTH(ID_WIDTH), .WB_ID(WB_ID), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_line(req_line),
    .busy(busy), .done(done), .err(err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] l, input int i);
    return l[i*32 +: 32];
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Slave: wmode 0 always ready, 1 toggles starting ready, 2 random.
  // awready rises aw_delay cycles into SEND, or aw_delay cycles after the last W beat when aw_after_w.
  // bvalid rises b_delay cycles after both AW and all W beats are done.
  task automatic run_burst(input logic [31:0] addr, input logic [255:0] line,
                           input int wmode, input bit aw_after_w, input int aw_delay,
                           input int b_delay, input logic [1:0] resp,
                           input bit keep, input logic [31:0] n_addr, input logic [255:0] n_line,
                           output int lat);
    int wn, awn, both_k, w_done_k;
    bit both, fin, wstall, awstall;
    logic [31:0] wd_prev;
    wn = 0; awn = 0; both_k = 0; w_done_k = 0;
    both = 0; fin = 0; wstall = 0; awstall = 0;
    wd_prev = '0;
    lat = -1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_line  = line;
    #1;
    chk("req_ready_idle", req_ready, 1);
    tick();
    if (keep) begin
      req_addr = n_addr;
      req_line = n_line;
    end else begin
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_line  = rand_line();
    end
    for (int k = 0; k < 300 && !fin; k++) begin
      case (wmode)
        0:       wready = 1'b1;
        1:       wready = (k % 2 == 0);
        default: wready = ($urandom_range(0, 99) < 60);
      endcase
      awready = aw_after_w ? (wn == 8 && (k - w_done_k) > aw_delay) : (k >= aw_delay);
      bvalid  = both && (k > both_k + b_delay);
      bresp   = resp;
      bid     = 4'(($urandom_range(0, 15)));
      #1;
      chk("busy", busy, 1);
      chk("req_ready_busy", req_ready, 0);
      chk("bready", bready, both && (k > both_k));
      chk("done", done, bvalid);
      if (wstall) begin
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_data", wdata, wd_prev);
      end
      if (awstall) chk("aw_hold_valid", awvalid, 1);
      if (wvalid && wready) begin
        chk("w_extra_beat", wn < 8, 1);
        chk("wdata", wdata, word_of(line, wn & 7));
        chk("wlast", wlast, wn == 7);
        chk("wstrb", wstrb, 4'hF);
        wn++;
        if (wn == 8) w_done_k = k;
      end
      if (awvalid && awready) begin
        chk("aw_extra", awn, 0);
        chk("awaddr", awaddr, {addr[31:5], 5'b00000});
        chk("awlen", awlen, 7);
        chk("awsize", awsize, 3'b010);
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, WB_ID);
        awn++;
      end
      if (!both && awn == 1 && wn == 8) begin
        both   = 1'b1;
        both_k = k;
      end
      if (bvalid && bready) begin
        fin = 1'b1;
        lat = k;
      end
      wstall  = wvalid && !wready;
      wd_prev = wdata;
      awstall = awvalid && !awready;
      tick();
    end
    bvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    #1;
    chk("burst_finished", fin, 1);
    chk("aw_count", awn, 1);
    chk("w_count", wn, 8);
    chk("post_busy", busy, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_done", done, 0);
    chk("post_valids", {awvalid, wvalid, bready}, 3'b000);
`ifdef WB_BRESP_CHECK_EN
    if (resp != 2'b00) err_exp = 1'b1;
`endif
    chk("err", err, err_exp);
  endtask

  logic [255:0] line_a, line_b, line_r;
  int lat;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_line = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_valids", {awvalid, wvalid, wlast, bready}, 4'b0000);

    // Zero-wait slave; accept cycle counts as cycle 1, so done lands in cycle 10.
    for (int i = 0; i < 8; i++) line_a[i*32 +: 32] = 32'hA000_0000 + i;
    run_burst(32'h1000_0044, line_a, 0, 1'b0, 0, 0, 2'b00, 1'b0, '0, '0, lat);
    chk("latency_zero_wait", lat, 8);

    // wready toggling.
    run_burst(32'h2000_1234, rand_line(), 1, 1'b0, 0, 0, 2'b00, 1'b0, '0, '0, lat);

    // awready 12 cycles after the final W beat.
    run_burst(32'h3000_00FF, rand_line(), 0, 1'b1, 12, 0, 2'b00, 1'b0, '0, '0, lat);
    chk("latency_aw_late", lat, 7 + 13 + 1);

    // req_valid held through the burst; the second line must wait for the cycle after done.
    line_a = rand_line();
    line_b = rand_line();
    run_burst(32'h4000_0020, line_a, 0, 1'b0, 2, 1, 2'b00, 1'b1, 32'h5000_0008, line_b, lat);
    run_burst(32'h5000_0008, line_b, 2, 1'b0, 1, 0, 2'b00, 1'b0, '0, '0, lat);

    // SLVERR response, then an OKAY one: err must stay where the first left it.
    run_burst(32'h6000_0000, rand_line(), 0, 1'b0, 0, 2, 2'b10, 1'b0, '0, '0, lat);
    run_burst(32'h6000_0100, rand_line(), 0, 1'b0, 0, 0, 2'b00, 1'b0, '0, '0, lat);

    // Reset at beat 4 abandons the burst.
    line_r = rand_line();
    req_valid = 1'b1; req_addr = 32'h7000_0010; req_line = line_r;
    wready = 1'b1; awready = 1'b1; bvalid = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("rst_beat4_data", wdata, word_of(line_r, 4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wready = 1'b0; awready = 1'b0;
    err_exp = 1'b0;
    chk("rst_mid_valids", {awvalid, wvalid, bready}, 3'b000);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    run_burst(32'h7000_0040, rand_line(), 0, 1'b0, 0, 0, 2'b00, 1'b0, '0, '0, lat);
    chk("latency_after_rst", lat, 8);

    // Randomized bursts.
    for (int n = 0; n < 8; n++) begin
      logic [1:0] r;
      r = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      run_burst($urandom, rand_line(), 2, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), r,
                1'b0, '0, '0, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
